// File: rtl/ucaspian_step_ctrl.sv
// uCaspian time-step sequencer: gathers per-unit step/clear status, waits for a
// settle window, pulses next_step and reports time to the host with back-pressure.
module ucaspian_step_ctrl #(
  parameter int unsigned NUM_UNITS = 6,
  parameter int unsigned TIME_W    = 32,
  parameter int unsigned TGT_W     = 8,
  parameter int unsigned SETTLE    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_act,
  input  logic                 clear_config,
  input  logic [NUM_UNITS-1:0] unit_step_done,
  input  logic [NUM_UNITS-1:0] unit_clear_done,
  input  logic                 output_busy,
  input  logic [TGT_W-1:0]     target_value,
  input  logic                 target_vld,
  output logic                 target_rdy,
  input  logic                 mode_free_run,
  input  logic                 halt_req,
  output logic                 next_step,
  output logic [TIME_W-1:0]    time_current,
  output logic                 time_remaining,
  output logic                 time_update,
  input  logic                 time_sent,
  output logic                 clear_done,
  input  logic                 ack_sent,
  output logic                 core_active
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_STEP, ST_REPORT} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [TIME_W-1:0] target_q, target_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic              tupd_q, tupd_d;
  logic              rem_q, rem_d;
  logic              rdy_q, rdy_d;
  logic              step_q, step_d;
  logic              clr_done_q;
  logic [TIME_W:0]   tgt_sum;
  logic              clearing;
  logic              all_done;

  assign clearing = clear_act || clear_config;
  assign all_done = (&unit_step_done) && !output_busy;
  assign tgt_sum  = {1'b0, target_q} + {{(TIME_W + 1 - TGT_W){1'b0}}, target_value};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    time_d   = time_q;
    tupd_d   = tupd_q;
    rdy_d    = !clearing;
    rem_d    = (mode_free_run && !halt_req) || (!mode_free_run && (target_q > time_q));

    // Carry out of the widened sum means the target would overflow: pin it at all-ones.
    if (target_vld && rdy_q) begin
      target_d = tgt_sum[TIME_W] ? '1 : tgt_sum[TIME_W-1:0];
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rem_q) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!rem_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!all_done) begin
          cnt_d = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_STEP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_STEP: begin
        time_d  = time_q + TIME_W'(1);
        tupd_d  = 1'b1;
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (time_sent) begin
          tupd_d  = 1'b0;
          state_d = rem_q ? ST_SETTLE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    step_d = (state_d == ST_STEP);

    if (clearing) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      target_d = '0;
      time_d   = '0;
      tupd_d   = 1'b0;
      rem_d    = 1'b0;
      rdy_d    = 1'b0;
      step_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      time_q   <= '0;
      tupd_q   <= 1'b0;
      rem_q    <= 1'b0;
      rdy_q    <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      time_q   <= time_d;
      tupd_q   <= tupd_d;
      rem_q    <= rem_d;
      rdy_q    <= rdy_d;
      step_q   <= step_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || ack_sent) begin
      clr_done_q <= 1'b0;
    end else if (clearing && (&unit_clear_done)) begin
      clr_done_q <= 1'b1;
    end
  end

  assign target_rdy     = rdy_q;
  assign next_step      = step_q;
  assign time_current   = time_q;
  assign time_remaining = rem_q;
  assign time_update    = tupd_q;
  assign clear_done     = clr_done_q;
  assign core_active    = !clearing && reset && (rem_q || (state_q != ST_IDLE));

endmodule

// File: tb/tb_ucaspian_step_ctrl.sv
// Self-checking bench for ucaspian_step_ctrl; an 8-bit time width keeps target
// saturation and time wrap reachable within a short run.
module tb_ucaspian_step_ctrl;

  localparam int unsigned NU = 6;
  localparam int unsigned TW = 8;
  localparam int unsigned GW = 8;
  localparam int unsigned ST = 2;

  logic          clk;
  logic          reset;
  logic          clear_act, clear_config;
  logic [NU-1:0] unit_step_done, unit_clear_done;
  logic          output_busy;
  logic [GW-1:0] target_value;
  logic          target_vld, target_rdy;
  logic          mode_free_run, halt_req;
  logic          next_step;
  logic [TW-1:0] time_current;
  logic          time_remaining, time_update, time_sent;
  logic          clear_done, ack_sent, core_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse = 0;
  int ad_run = 0;
  int host_wait = 0;
  logic prev_step = 1'b0;
  logic tu_prev = 1'b0;
  logic [TW-1:0] prev_time = '0;
  bit auto_ack = 0;
  bit rand_host = 0;

  ucaspian_step_ctrl #(
    .NUM_UNITS(NU), .TIME_W(TW), .TGT_W(GW), .SETTLE(ST)
  ) u_dut (
    .clk(clk), .reset(reset), .clear_act(clear_act), .clear_config(clear_config),
    .unit_step_done(unit_step_done), .unit_clear_done(unit_clear_done),
    .output_busy(output_busy), .target_value(target_value), .target_vld(target_vld),
    .target_rdy(target_rdy), .mode_free_run(mode_free_run), .halt_req(halt_req),
    .next_step(next_step), .time_current(time_current), .time_remaining(time_remaining),
    .time_update(time_update), .time_sent(time_sent), .clear_done(clear_done),
    .ack_sent(ack_sent), .core_active(core_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: edge, observe outputs, check step invariants, then play host.
  task automatic tick();
    logic [TW-1:0] exp_t;
    logic ad_now;
    ad_now = (&unit_step_done) && !output_busy;
    @(posedge clk);
    #1;
    cyc++;
    ad_run = ad_now ? ad_run + 1 : 0;
    if (prev_step) begin
      exp_t = prev_time + 1'b1;
      checks++;
      if (time_current !== exp_t) begin
        errors++;
        $display("FAIL step_incr: time_current=%0h expected %0h", time_current, exp_t);
      end
    end
    if (next_step === 1'b1) begin
      checks++;
      if (prev_step) begin
        errors++;
        $display("FAIL double_pulse: next_step high two cycles at cycle %0d", cyc);
      end
      checks++;
      if (ad_run < ST) begin
        errors++;
        $display("FAIL settle_window: step after %0d all-done cycles, need %0d", ad_run, ST);
      end
      checks++;
      if (tu_prev !== 1'b0 || time_update !== 1'b0) begin
        errors++;
        $display("FAIL backpressure: step with time_update prev=%b now=%b", tu_prev, time_update);
      end
      pulses++;
      last_pulse = cyc;
      prev_time = time_current;
    end
    prev_step = (next_step === 1'b1);
    tu_prev = time_update;
    if (auto_ack) begin
      time_sent = time_update;
    end else if (rand_host) begin
      if (time_update) begin
        if (host_wait == 0) time_sent = 1'b1;
        else begin host_wait--; time_sent = 1'b0; end
      end else begin
        time_sent = ($urandom_range(0, 3) == 0);
        host_wait = $urandom_range(0, 3);
      end
    end else begin
      time_sent = 1'b0;
    end
  endtask

  task automatic drive_idle();
    clear_act = 0; clear_config = 0; unit_step_done = '0; unit_clear_done = '0;
    output_busy = 0; target_value = '0; target_vld = 0; mode_free_run = 0;
    halt_req = 0; time_sent = 0; ack_sent = 0; auto_ack = 0; rand_host = 0;
    prev_step = 0;
  endtask

  task automatic reset_dut();
    drive_idle();
    reset = 0;
    tick(); tick();
    reset = 1;
    tick();
  endtask

  task automatic accept(input logic [GW-1:0] v);
    bit r;
    int n;
    target_value = v;
    target_vld = 1;
    n = 0;
    do begin
      r = target_rdy;
      tick();
      n++;
    end while (!r && n < 50);
    target_vld = 0;
    checks++;
    if (!r) begin
      errors++;
      $display("FAIL accept_timeout: target_rdy=%b expected 1", target_rdy);
    end
  endtask

  task automatic wait_pulse(input int bound, output int at);
    int p0;
    int n;
    p0 = pulses;
    n = 0;
    while (pulses == p0 && n < bound) begin tick(); n++; end
    checks++;
    if (pulses == p0) begin
      errors++;
      $display("FAIL pulse_timeout: no next_step within %0d cycles, pulses=%0d", bound, pulses);
    end
    at = last_pulse;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 0;
    tick(); tick();
    checks++;
    if ({target_rdy, next_step, time_remaining, time_update, clear_done, core_active, time_current} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b step=%b rem=%b upd=%b cd=%b act=%b t=%0h expected all 0",
               target_rdy, next_step, time_remaining, time_update, clear_done, core_active, time_current);
    end
    reset = 1;
    tick();
    checks++;
    if ({target_rdy, next_step, time_remaining, time_update, clear_done, core_active, time_current} !== {1'b1, 5'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_release: rdy=%b step=%b rem=%b upd=%b cd=%b act=%b t=%0h expected rdy=1 others 0",
               target_rdy, next_step, time_remaining, time_update, clear_done, core_active, time_current);
    end
  endtask

  task automatic test_target_run();
    int at, prev_at, p0;
    reset_dut();
    unit_step_done = '1;
    auto_ack = 1;
    p0 = pulses;
    prev_at = 0;
    accept(8'd3);
    for (int k = 1; k <= 3; k++) begin
      wait_pulse(40, at);
      tick();
      checks++;
      if (time_current !== TW'(k)) begin
        errors++;
        $display("FAIL run_time: time_current=%0d expected %0d", time_current, k);
      end
      if (k > 1) begin
        checks++;
        if (at - prev_at != int'(ST) + 2) begin
          errors++;
          $display("FAIL step_period: period=%0d expected %0d", at - prev_at, ST + 2);
        end
      end
      prev_at = at;
    end
    repeat (20) tick();
    checks++;
    if (pulses - p0 != 3 || {time_remaining, time_update, time_current} !== {2'b00, 8'd3}) begin
      errors++;
      $display("FAIL run_end: steps=%0d rem=%b upd=%b t=%0d expected 3 steps rem=0 upd=0 t=3",
               pulses - p0, time_remaining, time_update, time_current);
    end
  endtask

  task automatic test_settle_restart();
    int p, q, drop;
    reset_dut();
    unit_step_done = '1;
    auto_ack = 1;
    for (int pass = 0; pass < 2; pass++) begin
      accept(8'd2);
      wait_pulse(40, p);
      repeat (3) tick();
      drop = cyc + 1;
      if (pass == 0) unit_step_done = 6'b110111;
      else output_busy = 1'b1;
      tick();
      unit_step_done = '1;
      output_busy = 1'b0;
      wait_pulse(40, q);
      checks++;
      if (q != drop + int'(ST)) begin
        errors++;
        $display("FAIL settle_restart pass %0d: step at %0d expected %0d", pass, q, drop + ST);
      end
      repeat (20) tick();
    end
    checks++;
    if (time_current !== 8'd4) begin
      errors++;
      $display("FAIL settle_end: time_current=%0d expected 4", time_current);
    end
  endtask

  task automatic test_back_pressure();
    int p, q, r, p0, pstart;
    reset_dut();
    unit_step_done = '1;
    auto_ack = 1;
    pstart = pulses;
    accept(8'd5);
    wait_pulse(40, p);
    auto_ack = 0;
    tick();
    p0 = pulses;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({time_update, time_current} !== {1'b1, 8'd1} || pulses != p0) begin
        errors++;
        $display("FAIL hold_report: upd=%b t=%0d steps=%0d expected upd=1 t=1 steps=%0d",
                 time_update, time_current, pulses, p0);
      end
    end
    time_sent = 1'b1;
    auto_ack = 1;
    r = cyc + 1;
    wait_pulse(40, q);
    checks++;
    if (q != r + int'(ST)) begin
      errors++;
      $display("FAIL release_latency: step at %0d expected %0d", q, r + ST);
    end
    for (int k = 0; k < 3; k++) wait_pulse(40, q);
    repeat (20) tick();
    checks++;
    if (time_current !== 8'd5 || pulses - pstart != 5) begin
      errors++;
      $display("FAIL bp_end: t=%0d steps=%0d expected t=5 steps=5", time_current, pulses - pstart);
    end
  endtask

  task automatic test_saturate_wrap();
    int m, p0, n, at;
    logic [GW-1:0] vals [3];
    vals[0] = 8'hF0; vals[1] = 8'hFF; vals[2] = 8'hFF;
    reset_dut();
    unit_step_done = '1;
    auto_ack = 1;
    m = 0;
    foreach (vals[i]) begin
      accept(vals[i]);
      m = m + int'(vals[i]);
      if (m > 255) m = 255;
    end
    p0 = pulses;
    n = 0;
    while (pulses - p0 < m && n < 1500) begin tick(); n++; end
    repeat (20) tick();
    checks++;
    if (pulses - p0 != m || time_current !== TW'(m) || time_remaining !== 1'b0) begin
      errors++;
      $display("FAIL saturate: steps=%0d t=%0h rem=%b expected steps=%0d t=%0h rem=0",
               pulses - p0, time_current, time_remaining, m, m);
    end
    mode_free_run = 1;
    wait_pulse(40, at);
    halt_req = 1;
    p0 = pulses;
    tick();
    checks++;
    if (time_current !== 8'h00) begin
      errors++;
      $display("FAIL wrap: time_current=%0h expected 0", time_current);
    end
    repeat (20) tick();
    checks++;
    if (pulses != p0 || {time_remaining, time_update, core_active} !== 3'b000) begin
      errors++;
      $display("FAIL halt: extra steps=%0d rem=%b upd=%b act=%b expected 0 steps, all 0",
               pulses - p0, time_remaining, time_update, core_active);
    end
  endtask

  task automatic test_clear();
    int p, p0;
    reset_dut();
    unit_step_done = '1;
    accept(8'd5);
    wait_pulse(40, p);
    tick();
    checks++;
    if ({time_update, time_current} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL clear_setup: upd=%b t=%0d expected upd=1 t=1", time_update, time_current);
    end
    clear_act = 1;
    unit_clear_done = '0;
    tick();
    checks++;
    if ({time_current, time_update, time_remaining, next_step, target_rdy, core_active, clear_done} !== '0) begin
      errors++;
      $display("FAIL clear_zero: t=%0d upd=%b rem=%b step=%b rdy=%b act=%b cd=%b expected all 0",
               time_current, time_update, time_remaining, next_step, target_rdy, core_active, clear_done);
    end
    repeat (3) begin
      tick();
      checks++;
      if (clear_done !== 1'b0) begin
        errors++;
        $display("FAIL clear_wait: clear_done=%b expected 0", clear_done);
      end
    end
    unit_clear_done = '1;
    tick();
    checks++;
    if (clear_done !== 1'b1) begin
      errors++;
      $display("FAIL clear_set: clear_done=%b expected 1", clear_done);
    end
    repeat (3) tick();
    checks++;
    if (clear_done !== 1'b1) begin
      errors++;
      $display("FAIL clear_hold: clear_done=%b expected 1", clear_done);
    end
    ack_sent = 1;
    tick();
    checks++;
    if (clear_done !== 1'b0) begin
      errors++;
      $display("FAIL ack_priority: clear_done=%b expected 0", clear_done);
    end
    ack_sent = 0;
    tick();
    checks++;
    if (clear_done !== 1'b1) begin
      errors++;
      $display("FAIL clear_reset: clear_done=%b expected 1", clear_done);
    end
    clear_act = 0;
    clear_config = 1;
    tick();
    checks++;
    if ({clear_done, target_rdy} !== 2'b10) begin
      errors++;
      $display("FAIL clear_config: cd=%b rdy=%b expected cd=1 rdy=0", clear_done, target_rdy);
    end
    clear_config = 0;
    tick();
    checks++;
    if ({clear_done, target_rdy} !== 2'b11) begin
      errors++;
      $display("FAIL clear_release: cd=%b rdy=%b expected cd=1 rdy=1", clear_done, target_rdy);
    end
    ack_sent = 1;
    tick();
    ack_sent = 0;
    unit_clear_done = '0;
    auto_ack = 1;
    p0 = pulses;
    repeat (20) tick();
    checks++;
    if (pulses != p0 || {clear_done, time_remaining, core_active, time_current} !== 11'b0) begin
      errors++;
      $display("FAIL clear_after: steps=%0d cd=%b rem=%b act=%b t=%0d expected no steps, all 0",
               pulses - p0, clear_done, time_remaining, core_active, time_current);
    end
  endtask

  task automatic test_random();
    int m, n, v;
    reset_dut();
    rand_host = 1;
    m = 0;
    for (int round = 0; round < 8; round++) begin
      for (int a = 0; a < 2; a++) begin
        v = $urandom_range(0, 5);
        accept(GW'(v));
        m = m + v;
        if (m > 255) m = 255;
      end
      n = 0;
      while (n < 800 && !(time_current == TW'(m) && !time_update)) begin
        unit_step_done = ($urandom_range(0, 3) == 0) ? NU'($urandom) : '1;
        output_busy = ($urandom_range(0, 7) == 0);
        tick();
        n++;
      end
      repeat (10) begin
        unit_step_done = ($urandom_range(0, 3) == 0) ? NU'($urandom) : '1;
        output_busy = ($urandom_range(0, 7) == 0);
        tick();
      end
      checks++;
      if (time_current !== TW'(m) || time_remaining !== 1'b0) begin
        errors++;
        $display("FAIL random_round %0d: t=%0d rem=%b expected t=%0d rem=0",
                 round, time_current, time_remaining, m);
      end
    end
    rand_host = 0;
  endtask

  initial begin
    reset = 0;
    drive_idle();
    test_reset();
    test_target_run();
    test_settle_restart();
    test_back_pressure();
    test_saturate_wrap();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
